// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched
// -----------------------------------------------------------------------------
// Iterative DES key schedule that issues the 16 round subkeys in decryption
// order (K16 first, K1 last). It mirrors the encrypt-side schedule: C and D are
// rotated right instead of left, starting from the unrotated PC-1 halves.
// This works because the encrypt schedule rotates by 28 in total, so C16/D16
// equal C0/D0.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   key_in[63:0]   DES key, key_in[63] = DES bit 1, key_in[0] = DES bit 64
//   key_load       one-cycle strobe: capture key_in and (re)start a sequence
//   subkey[47:0]   current subkey, subkey[47] = PC-2 output bit 1
//   subkey_vld     subkey is valid
//   subkey_rdy     consumer accepts subkey when subkey_vld & subkey_rdy
//   round_idx[3:0] decrypt round index of subkey (0 = K16 ... 15 = K1)
//   busy           a sequence is in progress
//   done           one-cycle pulse after K1 has been accepted
//   key_parity_err 1 if any key byte had even parity at the last load
//                  (tied to 0 when PARITY_CHECK = 0)
// -----------------------------------------------------------------------------
module des_dec_key_sched #(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_load,
  output logic [47:0] subkey,
  output logic        subkey_vld,
  input  logic        subkey_rdy,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        key_parity_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // DES bit numbers (1-based, bit 1 = MSB). First 28 entries build C, the
  // remaining 28 build D.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Positions (1-based) within the 56-bit {C,D} word.
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [0:0]  state_reg;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic [47:0] subkey_reg;
  logic [3:0]  round_idx_reg;
  logic        vld_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [55:0] load_cd;
  logic [47:0] load_sk;
  logic [27:0] c_next;
  logic [27:0] d_next;
  logic [55:0] rot_cd;
  logic [47:0] rot_sk;
  logic        rot_one;
  logic        handshake;
  logic [7:0]  byte_even;

  genvar gi;

  // PC-1 of the incoming key: {C0, D0}, no rotation.
  for (gi = 0; gi < 56; gi++) begin : g_pc1
    assign load_cd[55-gi] = key_in[64-PC1[gi]];
  end

  // Right-rotation amount undoes the encrypt left shift of round 16-idx.
  // Encrypt shifts of 1 occur in rounds 1, 2, 9 and 16, i.e. when the
  // current decrypt index is 15, 14, 7 or 0. The rotation on idx 15 (the
  // final handshake) returns C/D to PC-1 of the key.
  assign rot_one = (round_idx_reg == 4'd0)  || (round_idx_reg == 4'd7) ||
                   (round_idx_reg == 4'd14) || (round_idx_reg == 4'd15);

  assign c_next = rot_one ? {c_reg[0], c_reg[27:1]} : {c_reg[1:0], c_reg[27:2]};
  assign d_next = rot_one ? {d_reg[0], d_reg[27:1]} : {d_reg[1:0], d_reg[27:2]};
  assign rot_cd = {c_next, d_next};

  // PC-2 is applied both to the freshly loaded halves (gives K16) and to the
  // rotated halves, so the next subkey is ready in the same cycle.
  for (gi = 0; gi < 48; gi++) begin : g_pc2
    assign load_sk[47-gi] = load_cd[56-PC2[gi]];
    assign rot_sk[47-gi]  = rot_cd[56-PC2[gi]];
  end

  // Odd parity is expected on each key byte; flag the even ones.
  for (gi = 0; gi < 8; gi++) begin : g_par
    assign byte_even[gi] = ~^key_in[8*gi +: 8];
  end

  assign handshake = (state_reg == ST_ISSUE) && vld_reg && subkey_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      c_reg         <= '0;
      d_reg         <= '0;
      subkey_reg    <= '0;
      round_idx_reg <= '0;
      vld_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // A load restarts from any state and wins over a same-cycle handshake.
      if (key_load) begin
        c_reg         <= load_cd[55:28];
        d_reg         <= load_cd[27:0];
        subkey_reg    <= load_sk;
        round_idx_reg <= 4'd0;
        vld_reg       <= 1'b1;
        busy_reg      <= 1'b1;
        state_reg     <= ST_ISSUE;
      end else if (handshake) begin
        c_reg <= c_next;
        d_reg <= d_next;
        if (round_idx_reg == 4'd15) begin
          // Last subkey taken: subkey and round_idx keep their final values.
          vld_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end else begin
          subkey_reg    <= rot_sk;
          round_idx_reg <= round_idx_reg + 4'd1;
        end
      end
    end
  end

  if (PARITY_CHECK != 0) begin : g_parity_on
    logic perr_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        perr_reg <= 1'b0;
      end else if (key_load) begin
        perr_reg <= |byte_even;
      end
    end
    assign key_parity_err = perr_reg;
  end else begin : g_parity_off
    logic unused_byte_even;
    assign unused_byte_even = |byte_even;
    assign key_parity_err   = 1'b0;
  end

  assign subkey     = subkey_reg;
  assign subkey_vld = vld_reg;
  assign round_idx  = round_idx_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// tb_des_dec_key_sched
// Directed bench for des_dec_key_sched. Subkeys are checked against a
// hand-computed table for the classic key 133457799BBCDFF1 and against a
// forward (left-rotating) encrypt-schedule model read back to front.
module tb_des_dec_key_sched;

  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'h0123456789ABCDEF;
  localparam logic [63:0] KP = 64'h133457799BBCDFF0;

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef struct {
    logic [3:0]  idx;
    logic [47:0] sk;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        subkey_rdy;
  logic [47:0] subkey;
  logic        subkey_vld;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        key_parity_err;
  logic [47:0] subkey0;
  logic        subkey_vld0;
  logic [3:0]  round_idx0;
  logic        busy0;
  logic        done0;
  logic        key_parity_err0;

  int n_vec;
  int n_err;
  vec_t tbl [16];

  des_dec_key_sched #(.PARITY_CHECK(1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .subkey(subkey), .subkey_vld(subkey_vld), .subkey_rdy(subkey_rdy),
    .round_idx(round_idx), .busy(busy), .done(done),
    .key_parity_err(key_parity_err)
  );

  des_dec_key_sched #(.PARITY_CHECK(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .subkey(subkey0), .subkey_vld(subkey_vld0), .subkey_rdy(subkey_rdy),
    .round_idx(round_idx0), .busy(busy0), .done(done0),
    .key_parity_err(key_parity_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encrypt-order subkey Kn (n = 1..16) built with left rotations.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] k;
    int sh;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_T[i]];
      d[27-i] = key[64-PC1_T[28+i]];
    end
    for (int r = 1; r <= n; r++) begin
      sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] key);
    key_in   = key;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  // Expects subkey K16 at idx 0 to be presented now; drains with rdy=1.
  task automatic run_seq(input logic [63:0] key, input bit use_tbl, input string tag);
    logic [47:0] exp_sk;
    for (int j = 0; j < 16; j++) begin
      exp_sk = model_k(key, 16 - j);
      if (use_tbl) begin
        chk({tag, "_tbl_sk"}, 64'(subkey), 64'(tbl[j].sk));
        chk({tag, "_tbl_idx"}, 64'(round_idx), 64'(tbl[j].idx));
      end
      chk({tag, "_model_sk"}, 64'(subkey), 64'(exp_sk));
      chk({tag, "_idx"}, 64'(round_idx), 64'(j));
      chk({tag, "_vld_busy_done"}, 64'({subkey_vld, busy, done}), 64'(3'b110));
      $display("%s round_idx=%0d subkey=%h", tag, round_idx, subkey);
      subkey_rdy = 1'b1;
      step();
    end
    chk({tag, "_end_vld_busy_done"}, 64'({subkey_vld, busy, done}), 64'(3'b001));
    chk({tag, "_end_hold"}, 64'({round_idx, subkey}), 64'({4'd15, model_k(key, 1)}));
    step();
    chk({tag, "_idle_vld_busy_done"}, 64'({subkey_vld, busy, done}), 64'(3'b000));
  endtask

  initial begin
    logic [63:0] rk;
    logic        hs;
    int          exp_j;
    int          dones;
    logic [47:0] exp_sk;

    n_vec = 0;
    n_err = 0;

    tbl[0]  = '{4'd0,  48'hCB3D8B0E17F5};
    tbl[1]  = '{4'd1,  48'hBF918D3D3F0A};
    tbl[2]  = '{4'd2,  48'h5F43B7F2E73A};
    tbl[3]  = '{4'd3,  48'h97C5D1FABA41};
    tbl[4]  = '{4'd4,  48'h7571F59467E9};
    tbl[5]  = '{4'd5,  48'h215FD3DED386};
    tbl[6]  = '{4'd6,  48'hB1F347BA464F};
    tbl[7]  = '{4'd7,  48'hE0DBEBEDE781};
    tbl[8]  = '{4'd8,  48'hF78A3AC13BFB};
    tbl[9]  = '{4'd9,  48'hEC84B7F618BC};
    tbl[10] = '{4'd10, 48'h63A53E507B2F};
    tbl[11] = '{4'd11, 48'h7CEC07EB53A8};
    tbl[12] = '{4'd12, 48'h72ADD6DB351D};
    tbl[13] = '{4'd13, 48'h55FC8A42CF99};
    tbl[14] = '{4'd14, 48'h79AED9DBC9E5};
    tbl[15] = '{4'd15, 48'h1B02EFFC7072};

    // 1. Reset overrides a simultaneous key_load.
    rst        = 1'b1;
    key_load   = 1'b1;
    subkey_rdy = 1'b0;
    key_in     = '0;
    for (int i = 0; i < 3; i++) begin
      rk     = {$urandom, $urandom};
      key_in = rk;
      step();
      chk("reset_outputs", 64'({subkey, subkey_vld, round_idx, busy, done, key_parity_err}), 64'd0);
      $display("reset cycle %0d key_in=%h", i, rk);
    end
    rst      = 1'b0;
    key_load = 1'b0;
    step();
    chk("post_reset_idle", 64'({subkey_vld, busy, done, key_parity_err}), 64'd0);

    // 2. Known vector, back-to-back.
    subkey_rdy = 1'b1;
    load(KA);
    chk("ka_parity", 64'(key_parity_err), 64'd0);
    run_seq(KA, 1'b1, "ka");
    // rdy ignored while idle
    step();
    chk("idle_ignores_rdy", 64'({subkey_vld, busy, done, round_idx}), 64'({3'b000, 4'd15}));

    // 3. Backpressure with pseudo-random rdy.
    subkey_rdy = 1'b0;
    load(KA);
    exp_j = 0;
    dones = 0;
    for (int cyc = 0; cyc < 400 && exp_j < 16; cyc++) begin
      if (subkey_vld) begin
        exp_sk = model_k(KA, 16 - exp_j);
        chk("bp_sk", 64'(subkey), 64'(exp_sk));
        chk("bp_idx", 64'(round_idx), 64'(exp_j));
      end
      subkey_rdy = 1'($urandom_range(0, 1));
      hs = subkey_vld && subkey_rdy;
      $display("bp cycle %0d rdy=%0d idx=%0d subkey=%h", cyc, subkey_rdy, round_idx, subkey);
      step();
      if (hs) exp_j++;
      if (done) dones++;
    end
    chk("bp_all_accepted", 64'(exp_j), 64'd16);
    chk("bp_end_vld_busy", 64'({subkey_vld, busy}), 64'd0);
    subkey_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dones++;
    end
    chk("bp_done_count", 64'(dones), 64'd1);

    // 4. Abort at round_idx 5 with key B.
    subkey_rdy = 1'b1;
    load(KA);
    for (int i = 0; i < 5; i++) step();
    chk("abort_at_idx", 64'(round_idx), 64'd5);
    key_in   = KB;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    run_seq(KB, 1'b0, "abort_kb");

    // 5. Parity flag.
    load(KP);
    chk("par_bad_flag", 64'(key_parity_err), 64'd1);
    chk("par_bad_flag_off", 64'(key_parity_err0), 64'd0);
    run_seq(KP, 1'b0, "par_kp");
    load(KA);
    chk("par_good_flag", 64'(key_parity_err), 64'd0);
    chk("par_good_flag_off", 64'(key_parity_err0), 64'd0);
    chk("par_off_same_sk", 64'(subkey0), 64'(subkey));
    run_seq(KA, 1'b0, "par_ka");

    // 6. key_load together with the final handshake.
    subkey_rdy = 1'b1;
    load(KA);
    for (int i = 0; i < 15; i++) step();
    chk("final_idx", 64'(round_idx), 64'd15);
    key_in   = KB;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("final_restart_no_done", 64'(done), 64'd0);
    run_seq(KB, 1'b0, "final_kb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/des_dec_key_sched.md
Name: des_dec_key_sched

Overview:
- Iterative DES key schedule that issues the 16 round subkeys in decryption order: K16 first, K1 last.
- Feeds the decrypt-side round datapath of the TDES core. The round datapath consumes one 48-bit subkey per round through the S-box stage.
- The encrypt side uses left rotations and runs K1 to K16. This block is its mirror: it uses right rotations and runs K16 to K1.
- One instance is used per DES stage of the TDES chain.

Parameters:
- PARITY_CHECK, 0: 1 enables the odd-parity check on each key byte and drives key_parity_err. 0 ties key_parity_err to 0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  64  DES key. key_in[63] is DES bit 1; key_in[0] is DES bit 64. Parity bits 8,16,…,64 are ignored by PC-1.
- key_load  input  1  one-cycle strobe; captures key_in and starts a 16-subkey sequence.
- subkey  output  48  current subkey. subkey[47] is PC-2 output bit 1.
- subkey_vld  output  1  subkey is valid.
- subkey_rdy  input  1  consumer accepts subkey when subkey_vld=1 and subkey_rdy=1.
- round_idx  output  4  decrypt round index of the current subkey: 0 means K16, 15 means K1.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse after K1 is accepted.
- key_parity_err  output  1  registered with the load; 1 if any key byte has even parity.

Behaviour:
- Reset: every output is 0, the C/D registers are 0, and the FSM is in IDLE. rst overrides all other inputs.
- FSM states: IDLE and ISSUE.
- IDLE:
  - key_load=1 captures the key. C,D <= PC-1(key_in), 28 bits each, with no rotation.
  - subkey <= PC-2(C0,D0), which equals K16 because the total encrypt rotation is 28.
  - round_idx <= 0, subkey_vld <= 1, busy <= 1; go to ISSUE.
  - Latency: subkey_vld is high on the cycle after key_load.
- ISSUE:
  - Hold subkey, round_idx and subkey_vld stable until subkey_vld and subkey_rdy are both 1.
  - On a handshake with round_idx < 15:
    - Rotate C and D right by r[round_idx+1], where r for indices 1..15 is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - subkey <= PC-2 of the rotated C,D, computed in the same cycle from the pre-rotation registers.
    - round_idx increments.
  - With subkey_rdy held high, subkeys are issued back-to-back at 1 per cycle: 16 subkeys in 16 cycles.
  - On a handshake with round_idx = 15:
    - subkey_vld <= 0, busy <= 0, done <= 1 for one cycle; go to IDLE.
    - round_idx and subkey hold their last values.
    - C,D have rotated a total of 28 positions and are back to PC-1 of the key, which is a check point.
- key_load asserted during ISSUE:
  - Aborts the current sequence and restarts exactly as in IDLE. key_load has priority over a simultaneous handshake.
  - The accepted subkey is discarded and done is not pulsed.
- key_load in the same cycle as the final handshake: the restart wins and done is not pulsed.
- key_parity_err:
  - Updated only on key_load: 1 if any of the 8 key bytes has an even number of ones.
  - The sequence runs regardless of the flag.
  - Cleared by rst or by a subsequent load of a good key.
- subkey_rdy is ignored while subkey_vld=0.
- Permutations PC-1 and PC-2 and the rotations are pure wiring and muxing. The only state is the C/D registers, the subkey register, the counter and the FSM.

Test Plan:
1. Reset behaviour: assert rst for 3 cycles with key_load=1 and key_in random. Required: all outputs 0 and no sequence starts.
2. Known vector: key_in=0x133457799BBCDFF1, pulse key_load, hold subkey_rdy=1.
   - Required on the next cycle: subkey=0xCB3D8B0E17F5 (K16) with round_idx=0.
   - Required 15 cycles later: subkey=0x1B02EFFC7072 (K1) with round_idx=15.
   - Required one cycle after that: done=1, busy=0, subkey_vld=0.
   - Required: the sequence matches a reference-model encrypt schedule reversed.
3. Backpressure: same key, toggle subkey_rdy pseudo-randomly. Required: subkey and round_idx stay stable while rdy=0, all 16 subkeys appear in order exactly once, and done pulses exactly once.
4. Abort: start key A (0x133457799BBCDFF1); at round_idx=5 pulse key_load with key B (0x0123456789ABCDEF). Required: next cycle round_idx=0 with subkey=K16 of B, no done for A, and the full B sequence completes.
5. Parity (PARITY_CHECK=1):
   - Load 0x133457799BBCDFF0. Required: key_parity_err=1 and the sequence still runs.
   - Reload 0x133457799BBCDFF1. Required: key_parity_err=0.
   - With PARITY_CHECK=0, the flag stays 0 for both keys.
6. Simultaneous final handshake and key_load at round_idx=15. Required: no done pulse, and the next cycle starts the new key at round_idx=0 with subkey_vld=1.
